// File: rtl/instr_register_ctrl.sv
// Queue controller for a 32-entry instruction register: round-robin intake from two
// requesters, a one-cycle registered write port, and a valid/ready pop port.
package instr_register_pkg;
    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  rez_t;
    } instruction_t;
endpackage

module instr_register_ctrl
    import instr_register_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  opcode_t      req0_opcode,
    input  operand_t     req0_op_a,
    input  operand_t     req0_op_b,
    input  opcode_t      req1_opcode,
    input  operand_t     req1_op_a,
    input  operand_t     req1_op_b,
    output logic         load_en,
    output address_t     write_pointer,
    output opcode_t      opcode,
    output operand_t     operand_a,
    output operand_t     operand_b,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         rd_valid,
    input  logic         rd_ready,
    output instruction_t rd_instr,
    input  logic         flush,
    output logic [5:0]   count,
    output logic         full,
    output logic         empty
);

    localparam logic [5:0] DEPTH = 6'd32;

    address_t   head_q, head_d, tail_q, tail_d, wp_q, wp_d;
    logic [5:0] count_q, count_d, alloc_q, alloc_d;
    logic       prio_q, prio_d;          // 0: req0 wins a tie, 1: req1 wins
    logic       load_en_q, load_en_d;
    opcode_t    opc_q, opc_d;
    operand_t   opa_q, opa_d, opb_q, opb_d;

    logic grant0_s, grant1_s, can_accept_s, accept_s, rd_valid_s, pop_s;

    // Arbitration and handshake qualifiers; handshakes are suppressed while in reset.
    always_comb begin
        grant0_s     = req0_valid && (!req1_valid || !prio_q);
        grant1_s     = req1_valid && (!req0_valid || prio_q);
        can_accept_s = reset_n && !flush && (alloc_q < DEPTH);
        req0_ready   = can_accept_s && grant0_s;
        req1_ready   = can_accept_s && grant1_s;
        accept_s     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        rd_valid_s   = reset_n && !flush && (count_q != 6'd0);
        pop_s        = rd_valid_s && rd_ready;
    end

    // Next-state: pointers, occupancy and the registered write port.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        alloc_d   = alloc_q;
        prio_d    = prio_q;
        load_en_d = 1'b0;
        wp_d      = wp_q;
        opc_d     = opc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        if (flush) begin
            head_d  = 5'd0;
            tail_d  = 5'd0;
            count_d = 6'd0;
            alloc_d = 6'd0;
        end else begin
            if (accept_s) begin
                load_en_d = 1'b1;
                wp_d      = tail_q;
                tail_d    = tail_q + 5'd1;
                prio_d    = grant0_s;
                if (grant0_s) begin
                    opc_d = req0_opcode;
                    opa_d = req0_op_a;
                    opb_d = req0_op_b;
                end else begin
                    opc_d = req1_opcode;
                    opa_d = req1_op_a;
                    opb_d = req1_op_b;
                end
            end else begin
                prio_d = prio_q;
            end
            if (pop_s) begin
                head_d = head_q + 5'd1;
            end else begin
                head_d = head_q;
            end
            // An entry becomes visible to the reader only once its write lands.
            count_d = count_q + {5'd0, load_en_q} - {5'd0, pop_s};
            alloc_d = alloc_q + {5'd0, accept_s}  - {5'd0, pop_s};
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q    <= 5'd0;
            tail_q    <= 5'd0;
            count_q   <= 6'd0;
            alloc_q   <= 6'd0;
            prio_q    <= 1'b0;
            load_en_q <= 1'b0;
            wp_q      <= 5'd0;
            opc_q     <= ZERO;
            opa_q     <= 32'sd0;
            opb_q     <= 32'sd0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            alloc_q   <= alloc_d;
            prio_q    <= prio_d;
            load_en_q <= load_en_d;
            wp_q      <= wp_d;
            opc_q     <= opc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
        end
    end

    // Output mapping.
    always_comb begin
        load_en       = load_en_q;
        write_pointer = wp_q;
        opcode        = opc_q;
        operand_a     = opa_q;
        operand_b     = opb_q;
        read_pointer  = head_q;
        rd_valid      = rd_valid_s;
        rd_instr      = instruction_word;
        count         = count_q;
        full          = (alloc_q == DEPTH);
        empty         = (count_q == 6'd0);
    end

endmodule

// File: tb/tb_instr_register_ctrl.sv
// Directed bench for instr_register_ctrl with a behavioural 32-entry instruction register.
module tb_instr_register_ctrl;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    opcode_t      req0_opcode, req1_opcode, opcode;
    operand_t     req0_op_a, req0_op_b, req1_op_a, req1_op_b, operand_a, operand_b;
    logic         load_en, rd_valid, rd_ready, flush, full, empty;
    address_t     write_pointer, read_pointer;
    instruction_t instruction_word, rd_instr;
    logic [5:0]   count;

    instruction_t mem [32];
    int checks = 0;
    int failures = 0;

    instr_register_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_opcode(req0_opcode), .req0_op_a(req0_op_a), .req0_op_b(req0_op_b),
        .req1_opcode(req1_opcode), .req1_op_a(req1_op_a), .req1_op_b(req1_op_b),
        .load_en(load_en), .write_pointer(write_pointer), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .read_pointer(read_pointer), .instruction_word(instruction_word),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_instr(rd_instr),
        .flush(flush), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Instruction register: written from the registered write port, read combinationally.
    always @(posedge clk) begin
        if (load_en)
            mem[write_pointer] <= {opcode, operand_a, operand_b, 32'hC0DE_C0DE, 27'd0, write_pointer};
    end
    assign instruction_word = mem[read_pointer];

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        req0_valid = 1'b0; req1_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0;
        req0_opcode = ZERO; req0_op_a = 32'sd0; req0_op_b = 32'sd0;
        req1_opcode = ZERO; req1_op_a = 32'sd0; req1_op_b = 32'sd0;

        // Reset values, with both requesters asserting valid.
        #1 reset_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        #2;
        check_val("rst_ready0", req0_ready, 0);
        check_val("rst_ready1", req1_ready, 0);
        check_val("rst_rd_valid", rd_valid, 0);
        check_val("rst_full", full, 0);
        check_val("rst_empty", empty, 1);
        check_val("rst_load_en", load_en, 0);
        check_val("rst_wp", write_pointer, 0);
        check_val("rst_rp", read_pointer, 0);
        check_val("rst_count", count, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Single write and read, accepted at the first edge after reset.
        req0_valid = 1'b1; req0_opcode = ADD; req0_op_a = 32'sd5; req0_op_b = 32'sd3;
        #1 check_val("t1_ready0", req0_ready, 1);
        step(); req0_valid = 1'b0;
        check_val("t1_load_en", load_en, 1);
        check_val("t1_wp", write_pointer, 0);
        check_val("t1_opcode", opcode, ADD);
        check_val("t1_op_a", operand_a, 5);
        check_val("t1_op_b", operand_b, 3);
        check_val("t1_count_pre", count, 0);
        step();
        check_val("t1_count", count, 1);
        check_val("t1_load_en_off", load_en, 0);
        check_val("t1_rd_valid", rd_valid, 1);
        check_val("t1_rp", read_pointer, 0);
        check_val("t1_rd_opc", rd_instr.opc, ADD);
        check_val("t1_rd_a", rd_instr.op_a, 5);
        check_val("t1_rd_b", rd_instr.op_b, 3);
        check_val("t1_rd_rez", rd_instr.rez_t, 64'hC0DE_C0DE_0000_0000);
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        check_val("t1_pop_count", count, 0);
        check_val("t1_pop_empty", empty, 1);
        check_val("t1_pop_rp", read_pointer, 1);

        // Lone req1 accepted, then flush discards the in-flight write.
        req1_valid = 1'b1; req1_opcode = PASSA; req1_op_a = 32'sd7; req1_op_b = 32'sd0;
        #1 check_val("fl_ready1", req1_ready, 1);
        step(); req1_valid = 1'b0;
        check_val("fl_load_en", load_en, 1);
        check_val("fl_wp", write_pointer, 1);
        flush = 1'b1; req0_valid = 1'b1;
        #1 check_val("fl_ready0_blocked", req0_ready, 0);
        check_val("fl_rd_valid", rd_valid, 0);
        step(); flush = 1'b0; req0_valid = 1'b0;
        check_val("fl_count", count, 0);
        check_val("fl_empty", empty, 1);
        check_val("fl_load_en_off", load_en, 0);
        check_val("fl_rp", read_pointer, 0);
        step();
        check_val("fl_no_commit", count, 0);

        // Contention: grants alternate starting with req0.
        req0_opcode = SUB;  req0_op_a = 32'sd10; req0_op_b = 32'sd1;
        req1_opcode = MULT; req1_op_a = 32'sd20; req1_op_b = 32'sd2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("ct_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
            check_val("ct_ready1", req1_ready, (i % 2 == 0) ? 0 : 1);
            step();
            check_val("ct_wp", write_pointer, i);
            check_val("ct_opcode", opcode, (i % 2 == 0) ? SUB : MULT);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        check_val("ct_count", count, 4);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("ct_rd_opc", rd_instr.opc, (i % 2 == 0) ? SUB : MULT);
            check_val("ct_rd_a", rd_instr.op_a, (i % 2 == 0) ? 10 : 20);
            step();
        end
        rd_ready = 1'b0;
        check_val("ct_drained", count, 0);

        // Fill to full from a clean queue, pop once, wrap the write pointer.
        flush = 1'b1; step(); flush = 1'b0;
        req0_valid = 1'b1; req0_opcode = ADD;
        for (int i = 0; i < 32; i++) begin
            req0_op_a = i;
            step();
        end
        check_val("fu_full", full, 1);
        check_val("fu_count_lag", count, 31);
        check_val("fu_ready0", req0_ready, 0);
        req1_valid = 1'b1; req1_op_a = 32'sd77;
        #1 check_val("fu_ready1", req1_ready, 0);
        step();
        check_val("fu_count", count, 32);
        check_val("fu_no_load", load_en, 0);
        req0_valid = 1'b0; req1_valid = 1'b0; rd_ready = 1'b1;
        step(); rd_ready = 1'b0;
        check_val("fu_pop_count", count, 31);
        check_val("fu_pop_full", full, 0);
        check_val("fu_pop_rp", read_pointer, 1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1 check_val("fu_one_ready", {req0_ready, req1_ready}, 2'b01);
        step(); req0_valid = 1'b0; req1_valid = 1'b0;
        check_val("fu_wrap_wp", write_pointer, 0);
        check_val("fu_wrap_opc", opcode, MULT);
        check_val("fu_wrap_a", operand_a, 77);
        check_val("fu_refull", full, 1);
        step();
        check_val("fu_count32", count, 32);

        // Drain to 5 entries, then stream accept+pop with head crossing 31->0.
        rd_ready = 1'b1;
        repeat (27) step();
        rd_ready = 1'b0;
        check_val("sm_count", count, 5);
        check_val("sm_rp", read_pointer, 28);
        check_val("sm_rd_a", rd_instr.op_a, 28);
        req0_valid = 1'b1; req0_op_a = 32'sd100;
        step();
        check_val("sm_fill_wp", write_pointer, 1);
        check_val("sm_fill_count", count, 5);
        rd_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            req0_op_a = 100 + i;
            step();
            check_val("sm_count_hold", count, 5);
            check_val("sm_wp", write_pointer, (1 + i) % 32);
        end
        check_val("sm_rp_wrap", read_pointer, 6);
        check_val("sm_rd_a6", rd_instr.op_a, 105);
        req0_valid = 1'b0; rd_ready = 1'b0;
        step();
        check_val("sm_count_final", count, 6);

        // Asynchronous reset between edges with a write in flight.
        req0_valid = 1'b1;
        step(); step();
        req0_valid = 1'b0;
        check_val("ar_count_pre", count, 7);
        check_val("ar_load_pre", load_en, 1);
        #2 reset_n = 1'b0;
        #1;
        check_val("ar_load_en", load_en, 0);
        check_val("ar_count", count, 0);
        check_val("ar_empty", empty, 1);
        check_val("ar_full", full, 0);
        check_val("ar_rd_valid", rd_valid, 0);
        check_val("ar_rp", read_pointer, 0);
        check_val("ar_wp", write_pointer, 0);
        check_val("ar_opcode", opcode, ZERO);
        check_val("ar_op_a", operand_a, 0);
        check_val("ar_op_b", operand_b, 0);
        @(posedge clk);
        #1 reset_n = 1'b1; req0_valid = 1'b1;
        step(); req0_valid = 1'b0;
        check_val("ar_first_load", load_en, 1);
        check_val("ar_first_wp", write_pointer, 0);
        step();
        check_val("ar_first_count", count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_register_ctrl.md
INSTR_REGISTER_CTRL -- requirements
Module: instr_register_ctrl

Interface
REQ-001 SHALL use: clk input 1 (sole clock, rising edge).
REQ-002 SHALL use: reset_n input 1 (asynchronous, active-low reset).
REQ-003 SHALL use: req0_valid/req1_valid input 1 each (requester N offers an instruction).
REQ-004 SHALL use: req0_ready/req1_ready output 1 each (instruction accepted when valid&&ready at a rising edge).
REQ-005 SHALL use: reqN_opcode input opcode_t, reqN_op_a input operand_t, reqN_op_b input operand_t (per-requester payload).
REQ-006 SHALL use: load_en output 1, write_pointer output address_t (5b), opcode output opcode_t, operand_a/operand_b output operand_t (instruction-register write port).
REQ-007 SHALL use: read_pointer output address_t; instruction_word input instruction_t (combinational read data for read_pointer).
REQ-008 SHALL use: rd_valid output 1, rd_ready input 1, rd_instr output instruction_t (consumer pop handshake).
REQ-009 SHALL use: flush input 1 (synchronous clear of queue state).
REQ-010 SHALL use: count output 6b (committed entries 0..32), full output 1, empty output 1.

Function
REQ-011 SHALL manage the 32-entry instruction register as a circular FIFO: tail (write) and head (read) 5-bit pointers, wrapping 31->0.
REQ-012 SHALL keep `alloc` = committed entries + in-flight writes (0..32); reqN_ready = !flush && (alloc < 32) && granted(N).
REQ-013 SHALL grant at most one requester per cycle, round-robin; after reset, req0 has priority; after a grant to N, the other requester has priority next cycle.
REQ-014 SHALL grant a lone valid requester regardless of priority; grant is combinational from valids and the priority bit.
REQ-015 On acceptance at edge E: load_en=1, write_pointer=tail, and opcode/operand_a/operand_b = accepted payload SHALL be registered at E and held for one cycle; tail increments at E.
REQ-016 The instruction register writes at edge E+1; count SHALL increment at E+1 (commit), never earlier.
REQ-017 load_en SHALL return to 0 after one cycle unless another acceptance occurs at E+1; back-to-back acceptances SHALL sustain one write per cycle.
REQ-018 SHALL drive read_pointer = head continuously; rd_valid = (count > 0) && !flush; rd_instr = instruction_word (pass-through).
REQ-019 On rd_valid&&rd_ready at an edge: head increments and count decrements; rd_ready while !rd_valid SHALL be ignored.
REQ-020 Simultaneous commit and pop in one cycle SHALL leave count unchanged; alloc SHALL change by +1 per accept and -1 per pop.
REQ-021 full = (alloc == 32); empty = (count == 0); with 31 allocated and both requesters valid, exactly one SHALL be accepted.
REQ-022 An entry SHALL never be overwritten before it is popped (guaranteed by REQ-012).
REQ-023 flush=1 at an edge SHALL set head=tail=0, count=alloc=0, load_en=0 at that edge; an in-flight write SHALL be discarded (no count increment); ready/rd_valid are 0 during flush.
REQ-024 The arbitration priority bit SHALL be unaffected by flush.
REQ-025 rd_instr.rez_t SHALL be passed through unmodified; the block computes no result.

Reset
REQ-026 reset_n=0 SHALL immediately force: load_en=0, write_pointer=0, read_pointer=0, opcode=ZERO, operand_a=operand_b=0, head=tail=0, count=alloc=0, priority=req0.
REQ-027 During reset: reqN_ready=0, rd_valid=0, full=0, empty=1; write in flight at reset assertion SHALL be lost.
REQ-028 First acceptance SHALL be possible at the first rising edge after reset_n deassertion.

Verification
REQ-029 Single write/read: req0 ADD a=5 b=3 -> load_en at wp=0 next cycle; count=1 one cycle later; rd_valid=1, read_pointer=0, rd_instr.opc=ADD, op_a=5, op_b=3.
REQ-030 Contention: req0, req1 both valid 4 cycles -> grants alternate 0,1,0,1; write_pointer 0,1,2,3; count reaches 4.
REQ-031 Full: 32 writes without pops -> full=1, both ready=0; one pop -> full=0 next cycle, next write to wp=0 (wrap); head=1.
REQ-032 Simultaneous: count=5, accept + pop every cycle for 10 cycles -> count stays 5 after pipeline fill; pointers wrap correctly.
REQ-033 Flush mid-write: accept at edge E, flush=1 at E+1 -> count=0, empty=1, head=tail=0; next write lands at wp=0.
REQ-034 Async reset: assert reset_n=0 between edges with count=7 -> outputs reach reset values without a clock edge; empty=1.
